// File: rtl/kamacore_writeback_arbiter.sv
// kamacore_writeback_arbiter: round-robin share of the single register-file write port
// Ports: clk, rst (sync, active-low), wb_stall, req_valid/req_addr/req_data (packed per requester),
// req_ready (combinational one-hot grant), destination_we/_a/_data (registered write port),
// pending_mask (one-hot of the in-flight destination).
// Optional build macro KAMACORE_WB_ZERO_DISCARD_EN: transfers to x0 are consumed but never written.
module kamacore_writeback_arbiter #(
  parameter int REQUESTERS = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CPU_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wb_stall,
  input  logic [REQUESTERS-1:0]                req_valid,
  input  logic [REQUESTERS*REG_ADDR_WIDTH-1:0] req_addr,
  input  logic [REQUESTERS*CPU_WIDTH-1:0]      req_data,
  output logic [REQUESTERS-1:0]                req_ready,
  output logic                                 destination_we,
  output logic [REG_ADDR_WIDTH-1:0]            destination_a,
  output logic [CPU_WIDTH-1:0]                 destination_data,
  output logic [2**REG_ADDR_WIDTH-1:0]         pending_mask
);
  localparam int PW = $clog2(REQUESTERS);
  logic [PW-1:0] rr_ptr, win, cand;
  logic found, go, write;
  logic [REG_ADDR_WIDTH-1:0] win_addr;
  always_comb begin
    win = '0;
    cand = '0;
    found = 1'b0;
    req_ready = '0;
    for (int o = 0; o < REQUESTERS; o++) begin
      cand = PW'((int'(rr_ptr) + o) % REQUESTERS);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
    if (rst && !wb_stall && found) req_ready[win] = 1'b1;
  end
  assign go = |req_ready;
  assign win_addr = req_addr[win*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
`ifdef KAMACORE_WB_ZERO_DISCARD_EN
  assign write = go && (win_addr != '0);
`else
  assign write = go;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
      destination_we <= 1'b0;
      destination_a <= '0;
      destination_data <= '0;
    end else begin
      destination_we <= write;
      if (go) begin
        rr_ptr <= (win == PW'(REQUESTERS - 1)) ? '0 : win + 1'b1;
        destination_a <= win_addr;
        destination_data <= req_data[win*CPU_WIDTH +: CPU_WIDTH];
      end
    end
  end
  assign pending_mask = {{(2**REG_ADDR_WIDTH-1){1'b0}}, destination_we} << destination_a;
endmodule

// File: tb/tb_kamacore_writeback_arbiter.sv
// tb_kamacore_writeback_arbiter: directed self-checking bench for the writeback arbiter
module tb_kamacore_writeback_arbiter;
  logic clk = 1'b0, rst, wb_stall;
  logic [2:0] req_valid, req_ready;
  logic [4:0] a [3];
  logic [31:0] d [3];
  logic destination_we;
  logic [4:0] destination_a;
  logic [31:0] destination_data, pending_mask;
  int checks = 0, errors = 0;
  logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [4:0] exp_a [6] = '{5'd3, 5'd4, 5'd5, 5'd3, 5'd4, 5'd5};
  kamacore_writeback_arbiter dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall), .req_valid(req_valid),
    .req_addr({a[2], a[1], a[0]}), .req_data({d[2], d[1], d[0]}),
    .req_ready(req_ready), .destination_we(destination_we), .destination_a(destination_a),
    .destination_data(destination_data), .pending_mask(pending_mask)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0; wb_stall = 1'b0; req_valid = 3'b111;
    a = '{5'd1, 5'd2, 5'd3}; d = '{32'h11, 32'h22, 32'h33};
    step(); step();
    chk("reset_ready", req_ready, 3'b000);
    chk("reset_we", destination_we, 1'b0);
    chk("reset_a", destination_a, 5'd0);
    chk("reset_data", destination_data, 32'd0);
    chk("reset_mask", pending_mask, 32'd0);
    rst = 1'b1; req_valid = 3'b010; a[1] = 5'd7; d[1] = 32'hDEAD_BEEF;
    #1 chk("single_ready", req_ready, 3'b010);
    step(); req_valid = 3'b000;
    chk("single_we", destination_we, 1'b1);
    chk("single_a", destination_a, 5'd7);
    chk("single_data", destination_data, 32'hDEAD_BEEF);
    chk("single_mask", pending_mask, 32'h80);
    step();
    chk("single_we_drop", destination_we, 1'b0);
    chk("single_a_hold", destination_a, 5'd7);
    chk("single_mask_drop", pending_mask, 32'd0);
    rst = 1'b0; step(); rst = 1'b1;
    a = '{5'd3, 5'd4, 5'd5}; d = '{32'hA0, 32'hA1, 32'hA2};
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_grant", req_ready, exp_g[i]);
      step();
      chk("rr_addr", destination_a, exp_a[i]);
      chk("rr_we", destination_we, 1'b1);
    end
    req_valid = 3'b010;
    #1 chk("wrap_setup", req_ready, 3'b010);
    step(); req_valid = 3'b011;
    #1 chk("wrap_g0", req_ready, 3'b001);
    step();
    chk("wrap_g0_data", destination_data, 32'hA0);
    chk("wrap_g1", req_ready, 3'b010);
    step(); req_valid = 3'b100;
    #1 chk("skip_g2", req_ready, 3'b100);
    step(); req_valid = 3'b111;
    #1 chk("ptr_zero", req_ready, 3'b001);
    req_valid = 3'b001; wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", req_ready, 3'b000);
      step();
      chk("stall_we", destination_we, 1'b0);
    end
    wb_stall = 1'b0;
    #1 chk("stall_ptr_frozen", req_ready, 3'b001);
    req_valid = 3'b010;
    #1 chk("pre_reset_g1", req_ready, 3'b010);
    step(); req_valid = 3'b101; rst = 1'b0;
    #1 chk("reset_void_ready", req_ready, 3'b000);
    step();
    chk("midreset_we", destination_we, 1'b0);
    chk("midreset_a", destination_a, 5'd0);
    rst = 1'b1;
    #1 chk("post_reset_g0", req_ready, 3'b001);
    req_valid = 3'b001; a[0] = 5'd0; d[0] = 32'h1234;
    #1 chk("zero_ready", req_ready, 3'b001);
    step(); req_valid = 3'b000;
`ifdef KAMACORE_WB_ZERO_DISCARD_EN
    chk("zero_we", destination_we, 1'b0);
    chk("zero_mask", pending_mask, 32'd0);
`else
    chk("zero_we", destination_we, 1'b1);
    chk("zero_a", destination_a, 5'd0);
    chk("zero_mask", pending_mask, 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
